// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the host
// loader/unloader port and NUM_CORES processor cores.
//   - Host has strict priority; cores are served round-robin.
//   - One transaction outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Ports:
//   clk_i, rst_i                    clock (rising), async active-high reset
//   host_req_i/we_i/addr_i/wdata_i  host request (held until host_ack_o)
//   host_ack_o                      one-cycle host completion pulse
//   core_req_i/we_i [NUM_CORES]     per-core request / write enable
//   core_addr_i/core_wdata_i        flat, core i at [i*W +: W]
//   core_ack_o [NUM_CORES]          one-hot one-cycle completion pulse
//   rdata_o                         registered read data, valid with ack
//   mem_en_o/we_o/addr_o/wdata_o    memory strobe and command
//   mem_rdata_i                     memory read data (1-cycle latency)
//   busy_o                          high whenever not IDLE
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        host_req_i,
    input  logic                        host_we_i,
    input  logic [ADDR_W-1:0]           host_addr_i,
    input  logic [DATA_W-1:0]           host_wdata_i,
    output logic                        host_ack_o,
    input  logic [NUM_CORES-1:0]        core_req_i,
    input  logic [NUM_CORES-1:0]        core_we_i,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr_i,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata_i,
    output logic [NUM_CORES-1:0]        core_ack_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        mem_en_o,
    output logic                        mem_we_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic                        busy_o
);

    localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic [IDW-1:0]       id_q;
    logic                 is_host_q;
    logic                 we_q;        // kept past ISSUE so WAIT knows read vs write
    logic                 mem_en_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 host_ack_q;
    logic [NUM_CORES-1:0] core_ack_q;

    // Round-robin pick: first requesting core at or after rr_ptr, wrapping.
    logic           core_any;
    logic [IDW-1:0] core_win;

    always_comb begin
        core_any = 1'b0;
        core_win = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!core_any && core_req_i[(int'(rr_ptr_q) + k) % NUM_CORES]) begin
                core_any = 1'b1;
                core_win = IDW'((int'(rr_ptr_q) + k) % NUM_CORES);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            is_host_q   <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            host_ack_q  <= 1'b0;
            core_ack_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host_req_i) begin
                        state_q     <= S_ISSUE;
                        mem_en_q    <= 1'b1;
                        is_host_q   <= 1'b1;
                        we_q        <= host_we_i;
                        mem_we_q    <= host_we_i;
                        mem_addr_q  <= host_addr_i;
                        mem_wdata_q <= host_wdata_i;
                    end else if (core_any) begin
                        state_q     <= S_ISSUE;
                        mem_en_q    <= 1'b1;
                        is_host_q   <= 1'b0;
                        id_q        <= core_win;
                        we_q        <= core_we_i[core_win];
                        mem_we_q    <= core_we_i[core_win];
                        mem_addr_q  <= core_addr_i[int'(core_win)*ADDR_W +: ADDR_W];
                        mem_wdata_q <= core_wdata_i[int'(core_win)*DATA_W +: DATA_W];
                    end
                end
                S_ISSUE: begin
                    // Memory commits/samples at this edge; drop the strobe.
                    state_q  <= S_WAIT;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
                S_WAIT: begin
                    state_q <= S_RESP;
                    if (!we_q) rdata_q <= mem_rdata_i;
                    if (is_host_q) host_ack_q <= 1'b1;
                    else           core_ack_q[id_q] <= 1'b1;
                end
                S_RESP: begin
                    state_q    <= S_IDLE;
                    host_ack_q <= 1'b0;
                    core_ack_q <= '0;
                    // Host grants leave the core rotation untouched.
                    if (!is_host_q)
                        rr_ptr_q <= (id_q == IDW'(NUM_CORES-1)) ? '0 : id_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign host_ack_o  = host_ack_q;
    assign core_ack_o  = core_ack_q;
    assign rdata_o     = rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle synchronous memory model.
module tb_dmem_arbiter;
    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic           clk, rst;
    logic           host_req, host_we, host_ack;
    logic [AW-1:0]  host_addr;
    logic [DW-1:0]  host_wdata;
    logic [NC-1:0]  core_req, core_we, core_ack;
    logic [NC*AW-1:0] core_addr;
    logic [NC*DW-1:0] core_wdata;
    logic [DW-1:0]  rdata, mem_wdata, mem_rdata;
    logic           mem_en, mem_we, busy;
    logic [AW-1:0]  mem_addr;

    logic [DW-1:0]  mem [0:(1<<AW)-1];

    int checks = 0;
    int passed = 0;

    dmem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_ack_o(host_ack),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_ack_o(core_ack),
        .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        mem_rdata = '0;
        for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
        mem[16'h0010] = 16'h1234;

        // Reset state
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_core_ack", core_ack, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // Core2 read of 0x0010
        core_req = 4'b0100; core_addr[2*AW +: AW] = 16'h0010;
        tick(1);
        chk("t2_issue_en", mem_en, 1);
        chk("t2_issue_addr", mem_addr, 16'h0010);
        chk("t2_issue_we", mem_we, 0);
        chk("t2_busy", busy, 1);
        tick(1);
        chk("t2_wait_en", mem_en, 0);
        chk("t2_wait_ack", core_ack, 0);
        tick(1);
        chk("t2_resp_ack", core_ack, 4'b0100);
        chk("t2_resp_rdata", rdata, 16'h1234);
        core_req = '0;
        tick(1);
        chk("t2_idle_ack", core_ack, 0);
        chk("t2_idle_busy", busy, 0);

        // Reset returns rr_ptr to 0; all cores held -> 0,1,2,3,0
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int c = 0; c < NC; c++) core_addr[c*AW +: AW] = 16'h0010;
        core_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick(3);
            chk($sformatf("t3_ack%0d", g), core_ack, 4'b0001 << (g % NC));
            tick(1);
            chk($sformatf("t3_gap%0d", g), core_ack, 0);
        end
        core_req = '0;   // rr_ptr now 1

        // Host write vs core1 read at the same edge: host wins
        host_req = 1; host_we = 1; host_addr = 16'h0005; host_wdata = 16'h00AB;
        core_req = 4'b0010; core_addr[1*AW +: AW] = 16'h0005;
        tick(1);
        chk("t4_issue_we", mem_we, 1);
        chk("t4_issue_addr", mem_addr, 16'h0005);
        chk("t4_issue_wdata", mem_wdata, 16'h00AB);
        tick(2);
        chk("t4_host_ack", host_ack, 1);
        chk("t4_core_ack_none", core_ack, 0);
        host_req = 0;
        tick(2);
        chk("t4_c1_issue_we", mem_we, 0);
        tick(2);
        chk("t4_c1_ack", core_ack, 4'b0010);
        chk("t4_c1_rdata", rdata, 16'h00AB);
        chk("t4_c1_host_ack", host_ack, 0);
        core_req = '0;
        tick(1);

        // Core3 read then write: write leaves rdata unchanged
        core_req = 4'b1000; core_we = 4'b0000; core_addr[3*AW +: AW] = 16'h0010;
        tick(3);
        chk("t6_read_rdata", rdata, 16'h1234);
        core_req = '0;
        tick(1);
        core_req = 4'b1000; core_we = 4'b1000;
        core_addr[3*AW +: AW] = 16'h0020; core_wdata[3*DW +: DW] = 16'h5555;
        tick(1);
        chk("t6_issue_we", mem_we, 1);
        chk("t6_issue_wdata", mem_wdata, 16'h5555);
        tick(1);
        chk("t6_wait_we", mem_we, 0);
        tick(1);
        chk("t6_resp_ack", core_ack, 4'b1000);
        chk("t6_resp_rdata", rdata, 16'h1234);
        chk("t6_resp_we", mem_we, 0);
        chk("t6_mem_written", mem[16'h0020], 16'h5555);
        core_req = '0; core_we = '0;
        tick(1);

        // Reset during WAIT of a core2 read
        core_req = 4'b0100; core_addr[2*AW +: AW] = 16'h0010;
        tick(2);
        rst = 1'b1;
        #2;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_rdata", rdata, 0);
        core_req = 4'b0101; core_addr[0 +: AW] = 16'h0005;
        tick(1);
        chk("t5_rst_ack", core_ack, 0);
        chk("t5_rst_en", mem_en, 0);
        rst = 1'b0;
        tick(3);
        chk("t5_c0_ack", core_ack, 4'b0001);
        chk("t5_c0_rdata", rdata, 16'h00AB);
        tick(4);
        chk("t5_c2_ack", core_ack, 4'b0100);
        chk("t5_c2_rdata", rdata, 16'h1234);
        core_req = '0;
        tick(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
